struct_field_remap_pipe: RTL

//  Registered, handshaked packed-struct field remapper: copies NUM_FIELDS bit-fields from
//  an input struct into parametrised positions of an output struct, one beat per cycle.

---
 rtl/struct_remap_pkg.sv | 40 ++++
 rtl/remap_skid_buf.sv | 84 ++++++++
 rtl/struct_field_remap_pipe.sv | 97 +++++++++
 3 files changed

// File: rtl/struct_remap_pkg.sv
// rtl/struct_remap_pkg.sv - shared types and constants for the struct field remapper
// Purpose: fill-mode enum, field descriptor struct, skid-buffer state enum and a
//          helper that unpacks one field descriptor from the packed parameter vectors.
package struct_remap_pkg;

    localparam int MAX_FIELDS = 8;
    localparam int DESC_AW    = MAX_FIELDS * 16;

    typedef enum logic {
        ZERO = 1'b0,
        HOLD = 1'b1
    } fill_mode_e;

    typedef struct packed {
        logic [15:0] src_lsb;
        logic [15:0] dst_lsb;
        logic [15:0] width;
    } field_desc_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Field idx occupies bits [idx*16 +: 16] of each packed descriptor vector.
    function automatic field_desc_t get_field(
        input logic [DESC_AW-1:0] src_all,
        input logic [DESC_AW-1:0] dst_all,
        input logic [DESC_AW-1:0] wid_all,
        input int                 idx
    );
        field_desc_t fd;
        fd.src_lsb = 16'(src_all >> (16 * idx));
        fd.dst_lsb = 16'(dst_all >> (16 * idx));
        fd.width   = 16'(wid_all >> (16 * idx));
        return fd;
    endfunction

endpackage

// File: rtl/remap_skid_buf.sv
// rtl/remap_skid_buf.sv - 2-entry valid/ready skid buffer with registered ready
// Purpose: decouples producer and consumer; in_ready is a flop so there is no
//          combinational path from out_ready to in_ready. Strict FIFO order.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data W bits
//   out_valid/out_ready   downstream handshake, out_data W bits (head entry)
module remap_skid_buf
    import struct_remap_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         ready_q, ready_d;
    logic         push, pop;

    assign push = in_valid & ready_q;
    assign pop  = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d  = in_data;
                        state_d = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: head_d = in_data;
                    default: ;
                endcase
            end
            FULL: begin
                // ready_q is low in FULL, so only a pop can happen here.
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;

endmodule

// File: rtl/struct_field_remap_pipe.sv
// rtl/struct_field_remap_pipe.sv - registered, handshaked packed-struct field remapper
// Purpose: copies NUM_FIELDS bit-fields of in_data into configured positions of
//          out_data, one beat per cycle, latency 1, through a 2-entry skid buffer.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake, in_data IN_W bits
//   out_valid/out_ready   output handshake, out_data OUT_W bits
//   beat_count            accepted input beats, CNT_W bits, wraps
module struct_field_remap_pipe
    import struct_remap_pkg::*;
#(
    parameter int                       IN_W       = 3,
    parameter int                       OUT_W      = 21,
    parameter int                       NUM_FIELDS = 1,
    parameter logic [NUM_FIELDS*16-1:0] SRC_LSB    = {16'd2},
    parameter logic [NUM_FIELDS*16-1:0] DST_LSB    = {16'd15},
    parameter logic [NUM_FIELDS*16-1:0] FLD_W      = {16'd1},
    parameter fill_mode_e               FILL_MODE  = ZERO,
    parameter int                       CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] beat_count
);

    // Working width wide enough for both source extraction and destination placement.
    localparam int XW = (IN_W > OUT_W) ? IN_W : OUT_W;

    localparam logic [DESC_AW-1:0] SRC_ALL = DESC_AW'(SRC_LSB);
    localparam logic [DESC_AW-1:0] DST_ALL = DESC_AW'(DST_LSB);
    localparam logic [DESC_AW-1:0] WID_ALL = DESC_AW'(FLD_W);

    logic [OUT_W-1:0] hold_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] remapped;
    logic             accept;

    // stage[i+1] is stage[i] with field i written over it, so a higher index
    // overwrites any overlap left by a lower one.
    logic [NUM_FIELDS:0][XW-1:0] stage;

    if (NUM_FIELDS < 1 || NUM_FIELDS > MAX_FIELDS) begin : g_bad_num
        $error("struct_field_remap_pipe: NUM_FIELDS=%0d outside 1..%0d", NUM_FIELDS, MAX_FIELDS);
    end

    assign stage[0] = (FILL_MODE == HOLD) ? XW'(hold_q) : '0;

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
        localparam field_desc_t FD   = get_field(SRC_ALL, DST_ALL, WID_ALL, g);
        localparam logic [XW-1:0] MASK = ~({XW{1'b1}} << FD.width);

        if (FD.width == 16'd0 ||
            int'(FD.src_lsb) + int'(FD.width) > IN_W ||
            int'(FD.dst_lsb) + int'(FD.width) > OUT_W) begin : g_bad_field
            $error("struct_field_remap_pipe: field %0d out of range", g);
        end

        assign stage[g+1] = (stage[g] & ~(MASK << FD.dst_lsb))
                          | (((XW'(in_data) >> FD.src_lsb) & MASK) << FD.dst_lsb);
    end

    assign remapped = stage[NUM_FIELDS][OUT_W-1:0];
    assign accept   = in_valid & in_ready;
    assign cnt_d    = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            hold_q <= remapped;
            cnt_q  <= cnt_d;
        end
    end

    assign beat_count = cnt_q;

    remap_skid_buf #(
        .W (OUT_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (remapped),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule
